// File: rtl/ped_grant_arbiter.sv
// rtl/ped_grant_arbiter.sv - round-robin pedestrian grant controller with ack timeout
//
// Serves N_CH crossings against one traffic FSM. A request toggle edge marks a
// channel pending; when the light is RED, the next pending channel from rr_ptr
// upward receives a grant toggle and hold_red is raised until that channel acks
// or the ack timeout expires.
//
// Ports:
//   clk_main       main clock, rising edge
//   rst_main_n     asynchronous active-low reset
//   traffic_light  current light from traffic_fsm (2'b10 = RED)
//   req_toggle     per-channel request toggles (already in clk_main)
//   ack_toggle     per-channel walk-finished toggles (already in clk_main)
//   grant_toggle   per-channel grant toggles back to the ped domains
//   hold_red       high while a grant is outstanding
//   pending        registered per-channel pending flags
//   active_ch      granted channel index, valid while hold_red=1
//   timeout_err    one-cycle pulse when a grant is aborted for lack of ack
module ped_grant_arbiter #(
  parameter int N_CH        = 4,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic            clk_main,
  input  logic            rst_main_n,
  input  logic [1:0]      traffic_light,
  input  logic [N_CH-1:0] req_toggle,
  input  logic [N_CH-1:0] ack_toggle,
  output logic [N_CH-1:0] grant_toggle,
  output logic            hold_red,
  output logic [N_CH-1:0] pending,
  output logic [CH_W-1:0] active_ch,
  output logic            timeout_err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0] active_q, active_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [N_CH-1:0] prev_req_q, prev_ack_q;
  logic            timeout_q, timeout_d;

  logic [N_CH-1:0] req_edge, ack_edge, act_oh;
  logic [CH_W:0]   cand;
  logic [CH_W-1:0] sel_idx, rr_next;
  logic            sel_found, finish;

  assign req_edge = req_toggle ^ prev_req_q;
  assign ack_edge = ack_toggle ^ prev_ack_q;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      act_oh[i] = (CH_W'(i) == active_q);
    end
  end

  // Rotating search: first pending channel at or above rr_ptr, wrapping at N_CH.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(N_CH)) begin
        cand = cand - (CH_W+1)'(N_CH);
      end
      if (!sel_found && pending_q[cand[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[CH_W-1:0];
      end
    end
  end

  assign rr_next = (active_q == CH_W'(N_CH - 1)) ? '0 : active_q + CH_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    active_d  = active_q;
    rr_ptr_d  = rr_ptr_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
    finish    = 1'b0;
    // A repeat request from the channel currently walking is dropped.
    pending_d = pending_q | (req_edge & ~((state_q == ST_GRANTED) ? act_oh : '0));

    case (state_q)
      ST_IDLE: begin
        if (traffic_light == 2'b10 && sel_found) begin
          grant_d[sel_idx] = ~grant_q[sel_idx];
          active_d         = sel_idx;
          to_cnt_d         = '0;
          state_d          = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        // Ack is checked first so an ack on the last cycle beats the timeout.
        if (|(ack_edge & act_oh)) begin
          finish = 1'b1;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          finish    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear is applied after the set so it wins on the same channel.
    if (finish) begin
      pending_d = pending_d & ~act_oh;
      rr_ptr_d  = rr_next;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk_main or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      pending_q  <= '0;
      active_q   <= '0;
      rr_ptr_q   <= '0;
      to_cnt_q   <= '0;
      prev_req_q <= '0;
      prev_ack_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      rr_ptr_q   <= rr_ptr_d;
      to_cnt_q   <= to_cnt_d;
      prev_req_q <= req_toggle;
      prev_ack_q <= ack_toggle;
      timeout_q  <= timeout_d;
    end
  end

  assign grant_toggle = grant_q;
  assign pending      = pending_q;
  assign active_ch    = active_q;
  assign hold_red     = (state_q == ST_GRANTED);
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_ped_grant_arbiter.sv
// tb/tb_ped_grant_arbiter.sv - self-checking bench for ped_grant_arbiter
module tb_ped_grant_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   light;
  logic [N-1:0] req, ack;
  logic [N-1:0] grant_toggle, pending;
  logic         hold_red, timeout_err;
  logic [1:0]   active_ch;

  int n_vec = 0;
  int n_err = 0;

  ped_grant_arbiter #(.N_CH(N), .TIMEOUT_CYC(TO)) dut (
    .clk_main     (clk),
    .rst_main_n   (rst_n),
    .traffic_light(light),
    .req_toggle   (req),
    .ack_toggle   (ack),
    .grant_toggle (grant_toggle),
    .hold_red     (hold_red),
    .pending      (pending),
    .active_ch    (active_ch),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: a set of waiting channels, one grant slot, a rotating
  // start position and a cycle counter for the ack deadline.
  bit [N-1:0] m_pend, m_gt, m_prev_req, m_prev_ack;
  bit         m_granted, m_to;
  int         m_active, m_rr, m_cnt;

  task automatic model_reset();
    m_pend = '0; m_gt = '0; m_prev_req = '0; m_prev_ack = '0;
    m_granted = 0; m_to = 0; m_active = 0; m_rr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] new_pend;
    bit         done;
    new_pend = m_pend;
    done = 0;
    m_to = 0;
    for (int i = 0; i < N; i++) begin
      if ((req[i] != m_prev_req[i]) && !(m_granted && i == m_active)) new_pend[i] = 1;
    end
    if (!m_granted) begin
      if (light == 2'b10 && m_pend != 0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (!m_granted && m_pend[c]) begin
            m_granted = 1;
            m_active  = c;
            m_gt[c]   = ~m_gt[c];
            m_cnt     = 0;
          end
        end
      end
    end else if (ack[m_active] != m_prev_ack[m_active]) begin
      done = 1;
    end else if (m_cnt == TO - 1) begin
      done = 1;
      m_to = 1;
    end else begin
      m_cnt++;
    end
    if (done) begin
      new_pend[m_active] = 0;
      m_rr = (m_active + 1) % N;
      m_granted = 0;
    end
    m_pend = new_pend;
    m_prev_req = req;
    m_prev_ack = ack;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_pending", int'(pending), int'(m_pend));
    chk("m_hold_red", int'(hold_red), int'(m_granted));
    chk("m_grant_toggle", int'(grant_toggle), int'(m_gt));
    chk("m_timeout_err", int'(timeout_err), int'(m_to));
    if (m_granted) chk("m_active_ch", int'(active_ch), m_active);
  endtask

  // Inputs are set at the falling edge, the rising edge consumes them, and
  // results are sampled at the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    ack = '0;
    #1;
    model_reset();
    chk("rst_grant", int'(grant_toggle), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_hold", int'(hold_red), 0);
    chk("rst_active", int'(active_ch), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold2", int'(hold_red), 0);
    chk("rst_timeout2", int'(timeout_err), 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] e_pend;
    logic       e_hold;
    logic [3:0] e_gt;
    int         e_act;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Basic grant on channel 2, then round-robin over 0, 1, 3 starting at 3.
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 0};
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0000, 0};
    tbl[2]  = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100, 2};
    tbl[3]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 0};
    tbl[4]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 0};
    tbl[5]  = '{4'b1111, 4'b0100, 4'b1011, 1'b0, 4'b0100, 0};
    tbl[6]  = '{4'b1111, 4'b0100, 4'b1011, 1'b1, 4'b1100, 3};
    tbl[7]  = '{4'b1111, 4'b1100, 4'b0011, 1'b0, 4'b1100, 0};
    tbl[8]  = '{4'b1111, 4'b1100, 4'b0011, 1'b1, 4'b1101, 0};
    tbl[9]  = '{4'b1111, 4'b1101, 4'b0010, 1'b0, 4'b1101, 0};
    tbl[10] = '{4'b1111, 4'b1101, 4'b0010, 1'b1, 4'b1111, 1};
    tbl[11] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b1111, 0};
    tbl[12] = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b1111, 0};

    light = 2'b10;
    @(negedge clk);
    do_reset();

    for (int v = 0; v < 13; v++) begin
      req = tbl[v].req;
      ack = tbl[v].ack;
      cycle();
      chk($sformatf("tbl%0d_pending", v), int'(pending), int'(tbl[v].e_pend));
      chk($sformatf("tbl%0d_hold", v), int'(hold_red), int'(tbl[v].e_hold));
      chk($sformatf("tbl%0d_grant", v), int'(grant_toggle), int'(tbl[v].e_gt));
      if (tbl[v].e_hold) chk($sformatf("tbl%0d_active", v), int'(active_ch), tbl[v].e_act);
    end

    // Wait for RED: request held off for 50 cycles, grant one cycle after RED.
    light = 2'b00;
    req[1] = ~req[1];
    cycle();
    for (int i = 0; i < 50; i++) begin
      cycle();
      chk("wait_hold", int'(hold_red), 0);
      chk("wait_pend1", int'(pending[1]), 1);
      chk("wait_grant", int'(grant_toggle), 4'b1111);
    end
    light = 2'b10;
    cycle();
    chk("red_hold", int'(hold_red), 1);
    chk("red_active", int'(active_ch), 1);
    chk("red_grant", int'(grant_toggle), 4'b1101);

    // Stray events while channel 1 is granted.
    ack[3] = ~ack[3];
    req[1] = ~req[1];
    cycle();
    chk("stray_hold", int'(hold_red), 1);
    chk("stray_pend", int'(pending), 4'b0010);
    cycle();
    chk("stray_hold2", int'(hold_red), 1);
    ack[1] = ~ack[1];
    cycle();
    chk("stray_ack_hold", int'(hold_red), 0);
    chk("stray_ack_pend", int'(pending), 0);
    cycle();
    chk("stray_after_pend", int'(pending), 0);
    chk("stray_after_hold", int'(hold_red), 0);

    // Timeout on channel 0.
    req[0] = ~req[0];
    cycle();
    cycle();
    chk("to_rise", int'(hold_red), 1);
    chk("to_active", int'(active_ch), 0);
    for (int k = 1; k < TO; k++) begin
      cycle();
      chk("to_hold_wait", int'(hold_red), 1);
      chk("to_err_wait", int'(timeout_err), 0);
    end
    cycle();
    chk("to_err_pulse", int'(timeout_err), 1);
    chk("to_hold_drop", int'(hold_red), 0);
    chk("to_pend0", int'(pending[0]), 0);
    cycle();
    chk("to_err_single", int'(timeout_err), 0);

    // Ack on the final cycle beats the timeout.
    req[0] = ~req[0];
    cycle();
    cycle();
    chk("ackto_rise", int'(hold_red), 1);
    for (int k = 1; k < TO; k++) cycle();
    ack[0] = ~ack[0];
    cycle();
    chk("ackto_err", int'(timeout_err), 0);
    chk("ackto_hold", int'(hold_red), 0);

    // Reset mid-grant.
    req[2] = ~req[2];
    cycle();
    cycle();
    chk("mid_rise", int'(hold_red), 1);
    repeat (3) cycle();
    do_reset();
    cycle();
    chk("post_rst_hold", int'(hold_red), 0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) req[$urandom_range(N-1)] ^= 1'b1;
      if (m_granted && $urandom_range(5) == 0) ack[m_active] ^= 1'b1;
      else if ($urandom_range(9) == 0) ack[$urandom_range(N-1)] ^= 1'b1;
      light = ($urandom_range(3) != 0) ? 2'b10 : 2'($urandom_range(3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
